// File: rtl/adpcm_pkg.sv
// Shared constants and types for the G.726 ADPCM float/delay datapath.
package adpcm_pkg;

  localparam int SR_W   = 16;
  localparam int MAG_W  = 15;
  localparam int EXP_W  = 4;
  localparam int MANT_W = 6;
  localparam int FLT_W  = 11;

  // Delay-line home value: +0 with exponent 0 and mantissa 32
  localparam logic [FLT_W-1:0] INIT_VAL = 11'h020;

  // Mantissa used when the magnitude is zero
  localparam logic [MANT_W-1:0] ZERO_MANT = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pack sign, exponent and mantissa into the 11-bit float word
  function automatic logic [FLT_W-1:0] pack_float(input logic sign,
                                                  input logic [EXP_W-1:0] exp,
                                                  input logic [MANT_W-1:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/sr_mag_norm.sv
// Iterative shift-normaliser: shifts the magnitude left one bit per cycle
// until its top bit is set (or it is zero), tracking the exponent as it goes.
module sr_mag_norm
  import adpcm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start,
  input  logic               step,
  input  logic [MAG_W-1:0]   mag,
  output logic [EXP_W-1:0]   exp,
  output logic [MANT_W-1:0]  mant,
  output logic               zero,
  output logic               done
);

  logic [MAG_W-1:0] m_q;
  logic [EXP_W-1:0] exp_q;

  // Load a fresh magnitude at exponent 15, or shift one place per step
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      m_q   <= '0;
      exp_q <= '0;
    end else if (start) begin
      m_q   <= mag;
      exp_q <= 4'd15;
    end else if (step) begin
      m_q   <= m_q << 1;
      exp_q <= exp_q - 4'd1;
    end
  end

  assign zero = (m_q == '0);
  assign done = zero || m_q[MAG_W-1];
  assign exp  = exp_q;
  assign mant = m_q[MAG_W-1 -: MANT_W];

endmodule

// File: rtl/sr_float_delay.sv
// Converts reconstructed signal SR to 11-bit float SR0 and keeps the
// two-deep SR1/SR2 delay line feeding the pole predictor.
module sr_float_delay
  import adpcm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_in0,
  input  logic              scan_in1,
  input  logic              scan_in2,
  input  logic              scan_in3,
  input  logic              scan_in4,
  input  logic              scan_enable,
  input  logic              test_mode,
  output logic              scan_out0,
  output logic              scan_out1,
  output logic              scan_out2,
  output logic              scan_out3,
  output logic              scan_out4,
  input  logic              init,
  input  logic              sr_valid,
  output logic              sr_ready,
  input  logic [SR_W-1:0]   sr,
  output logic [FLT_W-1:0]  sr1,
  output logic [FLT_W-1:0]  sr2,
  output logic              out_valid
);

  state_t              state_q, state_d;
  logic                srs_q;
  logic [FLT_W-1:0]    sr1_q, sr2_q;
  logic                out_valid_q, sr_ready_q;

  logic                accept, step, commit;
  logic [MAG_W-1:0]    sr_neg, mag;
  logic [EXP_W-1:0]    norm_exp;
  logic [MANT_W-1:0]   norm_mant;
  logic                norm_zero, norm_done;
  logic [FLT_W-1:0]    sr0;
  logic                unused_dft;

  // Scan chain is stitched in after synthesis; RTL only ties it off
  assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                        scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  // Low 15 bits of -sr; 16'h8000 therefore maps to magnitude 0
  assign sr_neg = ~sr[MAG_W-1:0] + 15'd1;
  assign mag    = sr[SR_W-1] ? sr_neg : sr[MAG_W-1:0];

  sr_mag_norm u_norm (
    .clk   (clk),
    .reset (reset),
    .clear (init),
    .start (accept),
    .step  (step),
    .mag   (mag),
    .exp   (norm_exp),
    .mant  (norm_mant),
    .zero  (norm_zero),
    .done  (norm_done)
  );

  assign sr0 = norm_zero ? pack_float(srs_q, 4'd0, ZERO_MANT)
                         : pack_float(srs_q, norm_exp, norm_mant);

  // Handshake and normaliser sequencing
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sr_valid && sr_ready_q) begin
          accept  = 1'b1;
          state_d = NORM;
        end
      end
      NORM: begin
        if (norm_done) begin
          commit  = 1'b1;
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, sign latch, delay line and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset || init) begin
      state_q     <= IDLE;
      srs_q       <= 1'b0;
      sr1_q       <= INIT_VAL;
      sr2_q       <= INIT_VAL;
      out_valid_q <= 1'b0;
      sr_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == DONE);
      sr_ready_q  <= (state_d == IDLE);
      if (accept) begin
        srs_q <= sr[SR_W-1];
      end
      if (commit) begin
        sr2_q <= sr1_q;
        sr1_q <= sr0;
      end
    end
  end

  assign sr1       = sr1_q;
  assign sr2       = sr2_q;
  assign out_valid = out_valid_q;
  assign sr_ready  = sr_ready_q;

endmodule

// File: tb/tb_sr_float_delay.sv
// Self-checking bench for sr_float_delay: directed table, corner sequences
// and randomized samples against an arithmetic reference model.
module tb_sr_float_delay;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic        sr_valid = 1'b0;
  logic [15:0] sr = 16'h0000;
  logic        sr_ready;
  logic [10:0] sr1, sr2;
  logic        out_valid;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int compared = 0;
  int mismatched = 0;
  int ov_count = 0;

  typedef struct {
    logic [15:0] sr;
    logic [10:0] exp_sr1;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  sr_float_delay dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (1'b0),
    .scan_in1    (1'b0),
    .scan_in2    (1'b0),
    .scan_in3    (1'b0),
    .scan_in4    (1'b0),
    .scan_enable (1'b0),
    .test_mode   (1'b0),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4),
    .init        (init),
    .sr_valid    (sr_valid),
    .sr_ready    (sr_ready),
    .sr          (sr),
    .sr1         (sr1),
    .sr2         (sr2),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  // Count every cycle in which out_valid is high
  always @(posedge clk) begin
    if (out_valid) ov_count++;
  end

  // Reference float conversion: sign/magnitude, exponent = bit length
  function automatic logic [10:0] model_float(input logic [15:0] s);
    int v, mag, pos, mant;
    v = s;
    mag = s[15] ? ((65536 - v) % 32768) : v;
    if (mag == 0) return s[15] ? 11'h420 : 11'h020;
    pos = 0;
    for (int k = 0; k < 15; k++) if (mag >= (1 << k)) pos = k;
    mant = (pos >= 5) ? (mag >> (pos - 5)) : (mag << (5 - pos));
    return 11'((s[15] ? 1024 : 0) + (pos + 1) * 64 + mant);
  endfunction

  // Reference latency: NORM cycles plus the DONE cycle
  function automatic int model_latency(input logic [15:0] s);
    int v, mag, pos;
    v = s;
    mag = s[15] ? ((65536 - v) % 32768) : v;
    if (mag == 0) return 2;
    pos = 0;
    for (int k = 0; k < 15; k++) if (mag >= (1 << k)) pos = k;
    return 17 - (pos + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out, got no response, expected handshake", name);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Present one sample, wait for acceptance and for out_valid.
  // Returns with the bench sitting in the out_valid cycle.
  task automatic applyStimulus(input logic [15:0] s, output int lat, output bit ok);
    bit accepted = 0;
    ok  = 0;
    lat = 0;
    sr = s;
    sr_valid = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      if (sr_ready) accepted = 1;
      @(posedge clk);
      #1;
    end
    sr_valid = 1'b0;
    if (!accepted) begin
      timeoutFail("accept");
      return;
    end
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      timeoutFail("out_valid");
      return;
    end
    ok = 1;
  endtask

  initial begin
    int lat, cnt_before;
    bit ok;
    logic [10:0] prev, exp1;
    logic [15:0] s;

    vecs[0] = '{16'h0000, 11'h020, 2};
    vecs[1] = '{16'h8000, 11'h420, 2};
    vecs[2] = '{16'h0001, 11'h060, 16};
    vecs[3] = '{16'hFFFF, 11'h460, 16};
    vecs[4] = '{16'h7FFF, 11'h3FF, 2};
    vecs[5] = '{16'h4000, 11'h3E0, 2};
    vecs[6] = '{16'h0100, 11'h260, 8};
    vecs[7] = '{16'hC000, 11'h7E0, 2};
    vecs[8] = '{16'h0020, 11'h1A0, 11};

    // Reset then idle five cycles
    doReset();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_sr1", 32'(sr1), 32'h020);
    checkOutput("reset_sr2", 32'(sr2), 32'h020);
    checkOutput("reset_ready", 32'(sr_ready), 32'h1);
    checkOutput("reset_no_out_valid", 32'(ov_count), 32'h0);
    checkOutput("scan_out", 32'({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}), 32'h0);

    // Directed table
    prev = 11'h020;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].sr, lat, ok);
      if (ok) begin
        checkOutput($sformatf("tbl%0d_sr1", i), 32'(sr1), 32'(vecs[i].exp_sr1));
        checkOutput($sformatf("tbl%0d_sr2", i), 32'(sr2), 32'(prev));
        checkOutput($sformatf("tbl%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        checkOutput($sformatf("tbl%0d_ready_in_done", i), 32'(sr_ready), 32'h0);
        @(posedge clk);
        #1;
        checkOutput($sformatf("tbl%0d_pulse_end", i), 32'(out_valid), 32'h0);
        checkOutput($sformatf("tbl%0d_ready_back", i), 32'(sr_ready), 32'h1);
      end
      prev = vecs[i].exp_sr1;
    end

    // Back-to-back with sr_valid held high
    sr = 16'h7FFF;
    sr_valid = 1'b1;
    @(posedge clk);
    #1;
    sr = 16'h0001;
    checkOutput("b2b_ready_low", 32'(sr_ready), 32'h0);
    cnt_before = 0;
    while (!sr_ready && cnt_before < 40) begin
      @(posedge clk);
      #1;
      cnt_before++;
    end
    if (!sr_ready) timeoutFail("b2b_ready");
    checkOutput("b2b_first_sr1", 32'(sr1), 32'h3FF);
    @(posedge clk);
    #1;
    sr_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("b2b_second_lat", 32'(lat), 32'd16);
    checkOutput("b2b_sr2", 32'(sr2), 32'h3FF);
    checkOutput("b2b_sr1", 32'(sr1), 32'h060);
    @(posedge clk);
    #1;

    // init mid-NORM aborts the sample
    sr = 16'h0001;
    sr_valid = 1'b1;
    @(posedge clk);
    #1;
    sr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    cnt_before = ov_count;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    checkOutput("init_ready", 32'(sr_ready), 32'h1);
    checkOutput("init_sr1", 32'(sr1), 32'h020);
    checkOutput("init_sr2", 32'(sr2), 32'h020);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("init_no_out_valid", 32'(ov_count), 32'(cnt_before));

    // reset and init together mid-NORM
    applyStimulus(16'h1234, lat, ok);
    @(posedge clk);
    #1;
    sr = 16'h0003;
    sr_valid = 1'b1;
    @(posedge clk);
    #1;
    sr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cnt_before = ov_count;
    reset = 1'b1;
    init = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    init = 1'b0;
    checkOutput("rstinit_ready", 32'(sr_ready), 32'h1);
    checkOutput("rstinit_sr1", 32'(sr1), 32'h020);
    checkOutput("rstinit_sr2", 32'(sr2), 32'h020);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("rstinit_no_out_valid", 32'(ov_count), 32'(cnt_before));

    // Randomized samples against the reference model
    prev = 11'h020;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0: s = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
        1: s = 16'(-($urandom_range(0, 65535) >> $urandom_range(0, 15)));
        2: s = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
        default: s = 16'($urandom);
      endcase
      exp1 = model_float(s);
      applyStimulus(s, lat, ok);
      if (ok) begin
        checkOutput($sformatf("rnd%0d_sr1(sr=0x%0h)", i, s), 32'(sr1), 32'(exp1));
        checkOutput($sformatf("rnd%0d_sr2", i), 32'(sr2), 32'(prev));
        checkOutput($sformatf("rnd%0d_lat", i), 32'(lat), 32'(model_latency(s)));
      end
      prev = exp1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
